// File: rtl/pulse_gen_pkg.sv
// Shared constants and helpers for the pulse generator and its request slot.
package pulse_gen_pkg;

  // FSM state codes. The fourth code (2'b11) is unused and recovers to IDLE.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] HIGH = 2'b01;
  localparam logic [1:0] GAP  = 2'b10;

  // Default generics.
  localparam int CNT_W_DEF   = 16;
  localparam int MIN_LOW_DEF = 3;

  // A requested width of zero still produces a one-cycle pulse.
  // Operates on 32 bits so any counter width up to 32 can share it.
  function automatic logic [31:0] eff_width(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/pulse_req_slot.sv
// One-deep request holder: a valid bit plus the effective width it carries.
// A consume and a load in the same cycle hand the slot straight to the new
// request; a load into an occupied slot (without consume) is discarded.
module pulse_req_slot
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             consume_i,
  input  logic [CNT_W-1:0] width_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] width_o,
  output logic             drop_o
);

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             drop_q, drop_d;

  // Next-state of the slot: consume frees it, load fills it or is dropped.
  always_comb begin
    valid_d = valid_q;
    width_d = width_q;
    drop_d  = 1'b0;
    if (consume_i) begin
      valid_d = load_i;
      if (load_i) begin
        width_d = width_i;
      end
    end else if (load_i) begin
      if (valid_q) begin
        drop_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        width_d = width_i;
      end
    end
  end

  // Slot registers; the drop strobe is registered so it lands one cycle late.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      width_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      width_q <= width_d;
      drop_q  <= drop_d;
    end
  end

  assign valid_o = valid_q;
  assign width_o = width_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/pulse_gen.sv
// Trigger-to-pulse converter: fixed-width registered high pulse followed by
// a guaranteed MIN_LOW-cycle low gap, with one request queued while busy.
// CNT_W is limited to 32 bits by the shared width helper.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MIN_LOW = MIN_LOW_DEF
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             trig_i,
  input  logic [CNT_W-1:0] width_i,
  output logic             d_o,
  output logic             busy_o,
  output logic             pend_o,
  output logic             drop_o
);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_LOW - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_q, d_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] w_eff;
  logic             cnt_zero;
  logic             in_busy;
  logic             gap_exit;
  logic             launch_direct;
  logic             slot_load;
  logic             pend_valid;
  logic [CNT_W-1:0] pend_width;

  assign w_eff    = CNT_W'(eff_width(32'(width_i)));
  assign cnt_zero = (cnt_q == '0);
  assign in_busy  = (state_q == HIGH) || (state_q == GAP);
  assign gap_exit = (state_q == GAP) && cnt_zero;

  // A trigger launches directly only when nothing is queued ahead of it;
  // any other trigger while busy goes to the slot (queued or dropped there).
  assign launch_direct = trig_i && ((state_q == IDLE) || (gap_exit && !pend_valid));
  assign slot_load     = trig_i && in_busy && !launch_direct;

  pulse_req_slot #(
    .CNT_W (CNT_W)
  ) u_slot (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .load_i    (slot_load),
    .consume_i (gap_exit && pend_valid),
    .width_i   (w_eff),
    .valid_o   (pend_valid),
    .width_o   (pend_width),
    .drop_o    (drop_o)
  );

  // FSM and down-counter; decrements only happen behind the zero check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (trig_i) begin
          state_d = HIGH;
          cnt_d   = w_eff - ONE;
        end
      end
      HIGH: begin
        if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          if (pend_valid) begin
            state_d = HIGH;
            cnt_d   = pend_width - ONE;
          end else if (trig_i) begin
            state_d = HIGH;
            cnt_d   = w_eff - ONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    d_d    = (state_d == HIGH);
    busy_d = (state_d == HIGH) || (state_d == GAP);
  end

  // State, counter and output flops; reset truncates any pulse in flight.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
    end
  end

  assign d_o    = d_q;
  assign busy_o = busy_q;
  assign pend_o = pend_valid;

endmodule
